// File: rtl/id_ex_decode_stage.sv
// Decode stage front end plus ID/EX pipeline register for the RV32I-subset core.
// Decodes InstrD into execute-stage controls and the sign-extended immediate, registered into E.
module id_ex_decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic            ValidD,
    input  logic            StallE,
    input  logic            FlushE,
    output logic [2:0]      ALUControlE,
    output logic            ALUSrcE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic [1:0]      ResultSrcE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic            ValidE,
    output logic            IllegalE
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE= 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef struct packed {
        logic [2:0]      alu_ctrl;
        logic            alu_src;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
        logic            branch;
        logic            jump;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            valid;
        logic            illegal;
    } e_stage_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic            legal;
    e_stage_t        dec;
    e_stage_t        e_q;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign funct7 = InstrD[31:25];

    assign imm_i = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
    assign imm_s = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
    assign imm_b = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                    InstrD[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                    InstrD[30:21], 1'b0};

    // Control decode; anything not explicitly recognised leaves legal low.
    always_comb begin
        dec   = '0;
        legal = 1'b0;
        unique case (opcode)
            OP_R, OP_I: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = (opcode == OP_I);
                dec.imm       = (opcode == OP_I) ? imm_i : '0;
                legal         = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (opcode == OP_I || funct7 == F7_ZERO) dec.alu_ctrl = ALU_ADD;
                        else if (funct7 == F7_ALT)               dec.alu_ctrl = ALU_SUB;
                        else                                     legal = 1'b0;
                    end
                    3'b111: dec.alu_ctrl = ALU_AND;
                    3'b110: dec.alu_ctrl = ALU_OR;
                    3'b100: dec.alu_ctrl = ALU_XOR;
                    3'b010: dec.alu_ctrl = ALU_SLT;
                    3'b001: begin
                        dec.alu_ctrl = ALU_SHL;
                        legal        = (funct7 == F7_ZERO);
                    end
                    3'b101: begin
                        dec.alu_ctrl = ALU_SRA;
                        legal        = (funct7 == F7_ALT);
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                legal          = (funct3 == 3'b010);
                dec.alu_src    = 1'b1;
                dec.result_src = 2'b01;
                dec.reg_write  = 1'b1;
                dec.imm        = imm_i;
            end
            OP_STORE: begin
                legal         = (funct3 == 3'b010);
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.imm       = imm_s;
            end
            OP_BR: begin
                legal        = (funct3 == 3'b000);
                dec.alu_ctrl = ALU_SUB;
                dec.branch   = 1'b1;
                dec.imm      = imm_b;
            end
            OP_JAL: begin
                legal          = 1'b1;
                dec.jump       = 1'b1;
                dec.reg_write  = 1'b1;
                dec.result_src = 2'b10;
                dec.imm        = imm_j;
            end
            default: legal = 1'b0;
        endcase

        if (!ValidD) begin
            dec = '0;
        end else if (!legal) begin
            // Illegal slot keeps only its PC so the trap logic can report it.
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
            dec.pc      = PCD;
        end else begin
            dec.valid = 1'b1;
            dec.rd1   = RD1D;
            dec.rd2   = RD2D;
            dec.pc    = PCD;
            dec.rs1   = InstrD[19:15];
            dec.rs2   = InstrD[24:20];
            dec.rd    = InstrD[11:7];
        end
    end

    // ID/EX register: flush beats stall beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
        end else if (FlushE) begin
            e_q <= '0;
        end else if (!StallE) begin
            e_q <= dec;
        end
    end

    assign ALUControlE = e_q.alu_ctrl;
    assign ALUSrcE     = e_q.alu_src;
    assign RegWriteE   = e_q.reg_write;
    assign MemWriteE   = e_q.mem_write;
    assign ResultSrcE  = e_q.result_src;
    assign BranchE     = e_q.branch;
    assign JumpE       = e_q.jump;
    assign RD1E        = e_q.rd1;
    assign RD2E        = e_q.rd2;
    assign PCE         = e_q.pc;
    assign ImmExtE     = e_q.imm;
    assign Rs1E        = e_q.rs1;
    assign Rs2E        = e_q.rs2;
    assign RdE         = e_q.rd;
    assign ValidE      = e_q.valid;
    assign IllegalE    = e_q.illegal;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Directed bench for id_ex_decode_stage: hand-computed decode results, stall/flush and reset.
module tb_id_ex_decode_stage;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] I_SUB  = 32'h40B50533;
    localparam logic [31:0] I_LW   = 32'hFFC12283;
    localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    logic            clk;
    logic            rst_n;
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic            ValidD;
    logic            StallE;
    logic            FlushE;
    logic [2:0]      ALUControlE;
    logic            ALUSrcE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic [1:0]      ResultSrcE;
    logic            BranchE;
    logic            JumpE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] ImmExtE;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;
    logic            ValidE;
    logic            IllegalE;

    int vectors;
    int miscompares;

    logic [154:0] outs;
    assign outs = {ALUControlE, ALUSrcE, RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE,
                   RD1E, RD2E, PCE, ImmExtE, Rs1E, Rs2E, RdE, ValidE, IllegalE};

    id_ex_decode_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCD(PCD), .RD1D(RD1D), .RD2D(RD2D),
        .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE), .JumpE(JumpE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .IllegalE(IllegalE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are sampled on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rd1, input logic [31:0] rd2, input logic valid);
        InstrD = instr;
        PCD    = pc;
        RD1D   = rd1;
        RD2D   = rd2;
        ValidD = valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (outs !== 155'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        drive(I_SUB, 32'h20, 32'h5, 32'h6, 1'b1);
        step();
        // Async reset mid-cycle with a valid instruction held in E.
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (outs !== 155'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (ALUControlE !== 3'b001 || ValidE !== 1'b1 || RdE !== 5'd10 || PCE !== 32'h20) begin
            miscompares++;
            $display("FAIL reset_release_load: alu=%b valid=%b rd=%0d pc=%h expected alu=001 valid=1 rd=10 pc=20",
                     ALUControlE, ValidE, RdE, PCE);
        end
    endtask

    task automatic test_sub();
        drive(I_SUB, 32'h44, 32'h1111, 32'h2222, 1'b1);
        step();
        vectors++;
        if ({ALUControlE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE}
            !== {3'b001, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sub_ctrl: alu=%b rw=%b src=%b mw=%b res=%b br=%b j=%b expected 001 1 0 0 00 0 0",
                     ALUControlE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE);
        end
        vectors++;
        if ({Rs1E, Rs2E, RdE} !== {5'd10, 5'd11, 5'd10} || ValidE !== 1'b1 || IllegalE !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_fields: rs1=%0d rs2=%0d rd=%0d v=%b ill=%b expected 10 11 10 1 0",
                     Rs1E, Rs2E, RdE, ValidE, IllegalE);
        end
        vectors++;
        if (RD1E !== 32'h1111 || RD2E !== 32'h2222 || PCE !== 32'h44 || ImmExtE !== 32'h0) begin
            miscompares++;
            $display("FAIL sub_data: rd1=%h rd2=%h pc=%h imm=%h expected 1111 2222 44 0",
                     RD1E, RD2E, PCE, ImmExtE);
        end
    endtask

    task automatic test_lw();
        drive(I_LW, 32'h48, 32'h100, 32'h0, 1'b1);
        step();
        vectors++;
        if (ALUControlE !== 3'b000 || ALUSrcE !== 1'b1 || ResultSrcE !== 2'b01
            || RegWriteE !== 1'b1 || MemWriteE !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_ctrl: alu=%b src=%b res=%b rw=%b mw=%b expected 000 1 01 1 0",
                     ALUControlE, ALUSrcE, ResultSrcE, RegWriteE, MemWriteE);
        end
        vectors++;
        if (ImmExtE !== 32'hFFFFFFFC || RD1E !== 32'h100 || RdE !== 5'd5 || Rs1E !== 5'd2) begin
            miscompares++;
            $display("FAIL lw_data: imm=%h rd1=%h rd=%0d rs1=%0d expected fffffffc 100 5 2",
                     ImmExtE, RD1E, RdE, Rs1E);
        end
    endtask

    task automatic test_alu_table();
        // {instr, alu, alusrc, imm}
        logic [31:0] instr [8];
        logic [2:0]  alu   [8];
        logic        src   [8];
        logic [31:0] imm   [8];
        instr[0] = 32'h003140B3; alu[0] = 3'b100; src[0] = 1'b0; imm[0] = 32'h0;        // xor
        instr[1] = 32'h003120B3; alu[1] = 3'b101; src[1] = 1'b0; imm[1] = 32'h0;        // slt
        instr[2] = 32'h003110B3; alu[2] = 3'b110; src[2] = 1'b0; imm[2] = 32'h0;        // sll
        instr[3] = 32'h003170B3; alu[3] = 3'b010; src[3] = 1'b0; imm[3] = 32'h0;        // and
        instr[4] = 32'h003160B3; alu[4] = 3'b011; src[4] = 1'b0; imm[4] = 32'h0;        // or
        instr[5] = 32'hFFF00093; alu[5] = 3'b000; src[5] = 1'b1; imm[5] = 32'hFFFFFFFF; // addi -1
        instr[6] = 32'h4011D193; alu[6] = 3'b111; src[6] = 1'b1; imm[6] = 32'h00000401; // srai 1
        instr[7] = 32'h00A1E093; alu[7] = 3'b011; src[7] = 1'b1; imm[7] = 32'h0000000A; // ori 10
        for (int i = 0; i < 8; i++) begin
            drive(instr[i], 32'h80 + 32'(i * 4), 32'h7, 32'h9, 1'b1);
            step();
            vectors++;
            if (ALUControlE !== alu[i] || ALUSrcE !== src[i] || ImmExtE !== imm[i]
                || RegWriteE !== 1'b1 || IllegalE !== 1'b0) begin
                miscompares++;
                $display("FAIL alu_table[%0d]: alu=%b src=%b imm=%h rw=%b ill=%b expected %b %b %h 1 0",
                         i, ALUControlE, ALUSrcE, ImmExtE, RegWriteE, IllegalE, alu[i], src[i], imm[i]);
            end
        end
    endtask

    task automatic test_store_jal_branch();
        drive(32'hFE612C23, 32'h90, 32'h200, 32'h55, 1'b1);  // sw x6,-8(x2)
        step();
        vectors++;
        if (MemWriteE !== 1'b1 || RegWriteE !== 1'b0 || ALUSrcE !== 1'b1 || ALUControlE !== 3'b000
            || ImmExtE !== 32'hFFFFFFF8 || Rs2E !== 5'd6 || RD2E !== 32'h55) begin
            miscompares++;
            $display("FAIL sw: mw=%b rw=%b src=%b alu=%b imm=%h rs2=%0d rd2=%h expected 1 0 1 000 fffffff8 6 55",
                     MemWriteE, RegWriteE, ALUSrcE, ALUControlE, ImmExtE, Rs2E, RD2E);
        end
        drive(32'h008000EF, 32'h94, 32'h0, 32'h0, 1'b1);      // jal x1,8
        step();
        vectors++;
        if (JumpE !== 1'b1 || RegWriteE !== 1'b1 || ResultSrcE !== 2'b10 || ALUControlE !== 3'b000
            || ImmExtE !== 32'h8 || RdE !== 5'd1) begin
            miscompares++;
            $display("FAIL jal: j=%b rw=%b res=%b alu=%b imm=%h rd=%0d expected 1 1 10 000 8 1",
                     JumpE, RegWriteE, ResultSrcE, ALUControlE, ImmExtE, RdE);
        end
        drive(I_BEQ, 32'h98, 32'h3, 32'h3, 1'b1);
        step();
        vectors++;
        if (BranchE !== 1'b1 || ALUControlE !== 3'b001 || ALUSrcE !== 1'b0 || RegWriteE !== 1'b0
            || ImmExtE !== 32'hFFFFFFFC || PCE !== 32'h98) begin
            miscompares++;
            $display("FAIL beq: br=%b alu=%b src=%b rw=%b imm=%h pc=%h expected 1 001 0 0 fffffffc 98",
                     BranchE, ALUControlE, ALUSrcE, RegWriteE, ImmExtE, PCE);
        end
    endtask

    task automatic test_illegal_bubble();
        logic [31:0] bad [3];
        bad[0] = I_BAD;          // unknown opcode
        bad[1] = 32'h0011D193;   // srli
        bad[2] = 32'h403110B3;   // sll with funct7 0100000
        for (int i = 0; i < 3; i++) begin
            drive(bad[i], 32'hA0 + 32'(i), 32'h5, 32'h6, 1'b1);
            step();
            vectors++;
            if (outs !== {3'b000, 6'b0, 1'b0, 64'h0, 32'hA0 + 32'(i), 32'h0, 15'h0, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL illegal[%0d]: ill=%b v=%b rw=%b mw=%b alu=%b pc=%h rd1=%h expected ill=1 v=1 pc=%h rest 0",
                         i, IllegalE, ValidE, RegWriteE, MemWriteE, ALUControlE, PCE, RD1E, 32'hA0 + 32'(i));
            end
        end
        drive(I_SUB, 32'hB0, 32'h5, 32'h6, 1'b0);
        step();
        vectors++;
        if (outs !== 155'd0) begin
            miscompares++;
            $display("FAIL bubble_validd0: got %h expected 0", outs);
        end
    endtask

    task automatic test_stall_flush();
        drive(I_SUB, 32'h100, 32'h1234, 32'h5678, 1'b1);
        step();
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive((i == 1) ? I_BAD : I_LW, 32'h200 + 32'(i), 32'hDEAD, 32'hBEEF, 1'b1);
            step();
            vectors++;
            if (ALUControlE !== 3'b001 || ALUSrcE !== 1'b0 || ResultSrcE !== 2'b00 || PCE !== 32'h100
                || RD1E !== 32'h1234 || RD2E !== 32'h5678 || RdE !== 5'd10 || IllegalE !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: alu=%b src=%b res=%b pc=%h rd1=%h rd2=%h rd=%0d ill=%b expected 001 0 00 100 1234 5678 10 0",
                         i, ALUControlE, ALUSrcE, ResultSrcE, PCE, RD1E, RD2E, RdE, IllegalE);
            end
        end
        FlushE = 1'b1;
        step();
        vectors++;
        if (outs !== 155'd0) begin
            miscompares++;
            $display("FAIL flush_over_stall: got %h expected 0", outs);
        end
        StallE = 1'b0;
        FlushE = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(I_LW, 32'h300, 32'h40, 32'h0, 1'b1);
        step();
        drive(I_SUB, 32'h304, 32'h1, 32'h2, 1'b1);
        step();
        vectors++;
        if (ALUControlE !== 3'b001 || ResultSrcE !== 2'b00 || ALUSrcE !== 1'b0 || PCE !== 32'h304) begin
            miscompares++;
            $display("FAIL b2b_second: alu=%b res=%b src=%b pc=%h expected 001 00 0 304",
                     ALUControlE, ResultSrcE, ALUSrcE, PCE);
        end
        FlushE = 1'b1;
        step();
        vectors++;
        if (outs !== 155'd0) begin
            miscompares++;
            $display("FAIL b2b_flush: got %h expected 0", outs);
        end
        FlushE = 1'b0;
        drive(I_LW, 32'h308, 32'h100, 32'h0, 1'b1);
        step();
        vectors++;
        if (ResultSrcE !== 2'b01 || ImmExtE !== 32'hFFFFFFFC || PCE !== 32'h308 || ValidE !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_after_flush: res=%b imm=%h pc=%h v=%b expected 01 fffffffc 308 1",
                     ResultSrcE, ImmExtE, PCE, ValidE);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_sub();
        test_lw();
        test_alu_table();
        test_store_jal_branch();
        test_illegal_bubble();
        test_stall_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_decode_stage.md
Name: id_ex_decode_stage

Overview:
- Decode stage front end plus ID/EX pipeline register for the 5-stage RV32I-subset core.
- Decodes `InstrD` into the control signals the execute-stage ALU and datapath consume (`ALUControlE` and related signals), sign-extends the immediate, and registers the result into the E stage.
- Supports stall (hold), flush (bubble) and invalid-slot insertion.
- Producer-side counterpart of the execute ALU: its 3-bit `ALUControlE` encoding is the ALU's opcode space.

Parameters:
- XLEN, 32, datapath width for PC, register data and immediate.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- InstrD  in  32  fetched instruction, D stage
- PCD  in  XLEN  PC of InstrD
- RD1D  in  XLEN  register file read port 1 data
- RD2D  in  XLEN  register file read port 2 data
- ValidD  in  1  D slot holds a real instruction
- StallE  in  1  hold E register contents
- FlushE  in  1  load bubble into E register
- ALUControlE  out  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 shl1, 111 sra1
- ALUSrcE  out  1  0 = SrcB from RD2E, 1 = from ImmExtE
- RegWriteE  out  1  writeback enable
- MemWriteE  out  1  store enable
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- BranchE  out  1  beq
- JumpE  out  1  jal
- RD1E, RD2E, PCE, ImmExtE  out  XLEN each  registered data
- Rs1E, Rs2E, RdE  out  5 each  register indices
- ValidE  out  1  E slot valid
- IllegalE  out  1  unsupported encoding reached E

Behaviour:
- **Reset.** `rst_n` low asynchronously clears every output to 0, which is the bubble state. Release is synchronous to the next clk edge.
- **Latency.** One cycle. Decode is combinational from `InstrD` and is captured on the rising edge.
- **Update priority per edge.** FlushE > StallE > load.
  - FlushE=1: all outputs become 0. This applies even if StallE=1.
  - StallE=1, FlushE=0: all outputs hold.
  - Otherwise: load the decoded D-stage values.
- **ValidD=0 on load.** Loads a bubble: all outputs 0.
- **Field extraction.** Rs1 = `InstrD[19:15]`, Rs2 = `[24:20]`, Rd = `[11:7]`, captured for every valid load.
- **Opcode decode.**
  - 0110011 (R): funct3/funct7 map as follows, with RegWrite=1, ALUSrc=0, ResultSrc=00:
    - 000/0000000 → add
    - 000/0100000 → sub
    - 111 → and
    - 110 → or
    - 100 → xor
    - 010 → slt
    - 001/0000000 → shl1
    - 101/0100000 → sra1
  - 0010011 (I-ALU): addi, andi, ori, xori, slti, slli, srai map to the same opcodes. ALUSrc=1, RegWrite=1, I-immediate.
  - 0000011 funct3=010 (lw): add, ALUSrc=1, ResultSrc=01, RegWrite=1, I-immediate.
  - 0100011 funct3=010 (sw): add, ALUSrc=1, MemWrite=1, S-immediate.
  - 1100011 funct3=000 (beq): sub, ALUSrc=0, Branch=1, B-immediate.
  - 1101111 (jal): add, Jump=1, RegWrite=1, ResultSrc=10, J-immediate.
- **Shift amount.** The ALU shifts by 1 only, so the shift amount field is ignored.
- **Immediates.** Sign-extended from `InstrD[31]` to XLEN. B and J immediates have bit 0 = 0. R-type ImmExt = 0.
- **Illegal encodings.** Any opcode/funct combination not listed above (including sll/srl with a funct7 not listed, and srl) is illegal. It loads as follows:
  - IllegalE=1, ValidE=1, PCE captured.
  - All enables (RegWrite, MemWrite, Branch, Jump) = 0.
  - ALUControlE=000, other data fields 0.
- **Rd = x0.** RegWriteE stays as decoded; suppression happens at writeback, not here.
- **Reset mid-stall or mid-flush.** Reset dominates and the outputs are 0 immediately.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with a valid R-type loaded → all outputs 0 before the next edge; first edge after release with `InstrD`=0x40B50533, ValidD=1 loads normally.
- Load `InstrD`=0x40B50533 (sub x10,x10,x11), ValidD=1 → next cycle ALUControlE=001, RegWriteE=1, ALUSrcE=0, Rs1E=10, Rs2E=11, RdE=10, ValidE=1.
- Load `InstrD`=0xFFC12283 (lw x5,-4(x2)), RD1D=0x100 → ALUControlE=000, ALUSrcE=1, ResultSrcE=01, ImmExtE=0xFFFFFFFC, RD1E=0x100, RdE=5.
- Stall/flush: load sub, then hold StallE=1 for 3 cycles while `InstrD` changes → outputs unchanged. Then assert FlushE=1 together with StallE=1 → all outputs 0 next edge.
- Illegal and bubble:
  - `InstrD`=0x0000007F, ValidD=1 → IllegalE=1, ValidE=1, RegWriteE=0, MemWriteE=0.
  - ValidD=0 with any `InstrD` → all outputs 0.
- Branch immediate: `InstrD`=0xFE000EE3 (beq x0,x0,-4) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC.
